// File: rtl/ncl_wavefront_arbiter.sv
// rtl/ncl_wavefront_arbiter.sv - round-robin clocked arbiter driving four-phase NCL wavefronts into a pipeline head
module ncl_wavefront_arbiter #(
    parameter int N           = 4,
    parameter int BURST       = 2,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 64
) (
    input  logic         clk,
    input  logic         init_n,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt,
    output logic         wave_done,
    output logic         pipe_a,
    input  logic         pipe_ack,
    output logic         busy,
    output logic         timeout_err,
    input  logic         clr_err
);
    localparam int PTR_W   = $clog2(N);
    localparam int TIMER_W = $clog2(TIMEOUT + 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);
    localparam logic [8:0]         BURST_LIM  = 9'(BURST);
    localparam logic [PTR_W:0]     N_W        = (PTR_W + 1)'(N);
    localparam logic [PTR_W-1:0]   PTR_MAX    = PTR_W'(N - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_NULL, ST_ERR} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] ack_sync;
    logic                   ack_s;
    logic [PTR_W-1:0]       rr_ptr;
    logic [PTR_W-1:0]       winner;
    logic [PTR_W-1:0]       pick;
    logic                   pick_found;
    logic [PTR_W:0]         scan_idx;
    logic [PTR_W-1:0]       after_winner;
    logic [7:0]             beat;
    logic [8:0]             beat_next;
    logic [TIMER_W-1:0]     timer;
    logic                   timer_expired;

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            ack_sync <= '0;
        end else begin
            ack_sync <= {ack_sync[SYNC_STAGES-2:0], pipe_ack};
        end
    end

    assign ack_s = ack_sync[SYNC_STAGES-1];

    // First requester at or after rr_ptr, wrapping N-1 -> 0.
    always_comb begin
        pick       = '0;
        pick_found = 1'b0;
        scan_idx   = '0;
        for (int i = 0; i < N; i++) begin
            scan_idx = {1'b0, rr_ptr} + (PTR_W + 1)'(i);
            if (scan_idx >= N_W) begin
                scan_idx = scan_idx - N_W;
            end
            if (!pick_found && req[scan_idx[PTR_W-1:0]]) begin
                pick       = scan_idx[PTR_W-1:0];
                pick_found = 1'b1;
            end
        end
    end

    assign after_winner  = (winner == PTR_MAX) ? '0 : winner + PTR_W'(1);
    assign beat_next     = {1'b0, beat} + 9'd1;
    assign timer_expired = (timer == TIMER_LAST);

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            state       <= ST_IDLE;
            gnt         <= '0;
            pipe_a      <= 1'b0;
            wave_done   <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            rr_ptr      <= '0;
            winner      <= '0;
            beat        <= '0;
            timer       <= '0;
        end else begin
            wave_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // A pipeline still holding DATA (ack_s high) must drain before any new grant.
                    if (pick_found && !ack_s) begin
                        winner <= pick;
                        gnt    <= N'(1) << pick;
                        pipe_a <= 1'b1;
                        busy   <= 1'b1;
                        beat   <= '0;
                        timer  <= '0;
                        state  <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (ack_s) begin
                        pipe_a <= 1'b0;
                        timer  <= '0;
                        state  <= ST_NULL;
                    end else if (timer_expired) begin
                        pipe_a      <= 1'b0;
                        gnt         <= '0;
                        timeout_err <= 1'b1;
                        rr_ptr      <= after_winner;
                        timer       <= '0;
                        state       <= ST_ERR;
                    end else begin
                        timer <= timer + TIMER_W'(1);
                    end
                end
                ST_NULL: begin
                    if (!ack_s) begin
                        wave_done <= 1'b1;
                        beat      <= beat_next[7:0];
                        timer     <= '0;
                        if ((beat_next < BURST_LIM) && req[winner]) begin
                            pipe_a <= 1'b1;
                            state  <= ST_DATA;
                        end else begin
                            gnt    <= '0;
                            rr_ptr <= after_winner;
                            busy   <= 1'b0;
                            state  <= ST_IDLE;
                        end
                    end else if (timer_expired) begin
                        gnt         <= '0;
                        timeout_err <= 1'b1;
                        rr_ptr      <= after_winner;
                        timer       <= '0;
                        state       <= ST_ERR;
                    end else begin
                        timer <= timer + TIMER_W'(1);
                    end
                end
                ST_ERR: begin
                    if (clr_err) begin
                        timeout_err <= 1'b0;
                        busy        <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ncl_wavefront_arbiter.sv
// tb/tb_ncl_wavefront_arbiter.sv - self-checking bench for ncl_wavefront_arbiter
module tb_ncl_wavefront_arbiter;
    localparam int N       = 4;
    localparam int BURST   = 2;
    localparam int SYNC    = 2;
    localparam int TIMEOUT = 64;
    localparam int S_IDLE = 0, S_DATA = 1, S_NULL = 2, S_ERR = 3;

    logic         clk = 1'b0;
    logic         init_n = 1'b0;
    logic [N-1:0] req = '0;
    logic [N-1:0] gnt;
    logic         wave_done;
    logic         pipe_a;
    logic         pipe_ack = 1'b0;
    logic         busy;
    logic         timeout_err;
    logic         clr_err = 1'b0;

    ncl_wavefront_arbiter #(
        .N(N), .BURST(BURST), .SYNC_STAGES(SYNC), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .init_n(init_n), .req(req), .gnt(gnt), .wave_done(wave_done),
        .pipe_a(pipe_a), .pipe_ack(pipe_ack), .busy(busy),
        .timeout_err(timeout_err), .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Pipeline environment: ack follows pipe_a after pdelay cycles, or is forced.
    int           pdelay = 3;
    bit           ack_mode = 1'b0;
    bit           ack_force = 1'b0;
    logic [15:0]  hist = '0;

    initial forever begin
        @(negedge clk);
        #1;
        hist = {hist[14:0], pipe_a};
        pipe_ack = ack_mode ? ack_force : hist[pdelay];
    end

    // Behavioural reference model
    int           m_state = S_IDLE;
    int           m_ptr = 0, m_win = 0, m_beat = 0, m_timer = 0;
    logic         m_a = 1'b0, m_done = 1'b0, m_err = 1'b0;
    logic [N-1:0] m_gnt = '0;
    logic [SYNC-1:0] m_sync = '0;

    task automatic model_reset();
        m_state = S_IDLE; m_ptr = 0; m_win = 0; m_beat = 0; m_timer = 0;
        m_a = 1'b0; m_done = 1'b0; m_err = 1'b0; m_gnt = '0; m_sync = '0;
    endtask

    task automatic model_fail();
        m_a = 1'b0; m_gnt = '0; m_err = 1'b1;
        m_ptr = (m_win + 1) % N; m_timer = 0; m_state = S_ERR;
    endtask

    task automatic model_step();
        logic seen_ack;
        bit   found;
        seen_ack = m_sync[SYNC-1];
        m_sync = {m_sync[SYNC-2:0], pipe_ack};
        m_done = 1'b0;
        case (m_state)
            S_IDLE: if (req != '0 && !seen_ack) begin
                found = 1'b0;
                for (int i = 0; i < N; i++) begin
                    if (!found && req[(m_ptr + i) % N]) begin
                        m_win = (m_ptr + i) % N;
                        found = 1'b1;
                    end
                end
                m_gnt = '0; m_gnt[m_win] = 1'b1;
                m_a = 1'b1; m_beat = 0; m_timer = 0; m_state = S_DATA;
            end
            S_DATA: begin
                if (seen_ack) begin
                    m_a = 1'b0; m_timer = 0; m_state = S_NULL;
                end else begin
                    m_timer++;
                    if (m_timer >= TIMEOUT) model_fail();
                end
            end
            S_NULL: begin
                if (!seen_ack) begin
                    m_done = 1'b1;
                    m_beat++;
                    m_timer = 0;
                    if (m_beat < BURST && req[m_win]) begin
                        m_a = 1'b1; m_state = S_DATA;
                    end else begin
                        m_gnt = '0; m_ptr = (m_win + 1) % N; m_state = S_IDLE;
                    end
                end else begin
                    m_timer++;
                    if (m_timer >= TIMEOUT) model_fail();
                end
            end
            default: if (clr_err) begin
                m_err = 1'b0; m_state = S_IDLE;
            end
        endcase
    endtask

    initial forever begin
        @(posedge clk or negedge init_n);
        if (!init_n) model_reset();
        else model_step();
    end

    // Compare process plus grant-sequence monitor
    int           gq[$];
    int           wdq[$];
    int           cur_wd = 0;
    logic [N-1:0] prev_gnt = '0;

    initial forever begin
        @(posedge clk);
        #1;
        check("gnt", gnt, m_gnt);
        check("pipe_a", pipe_a, m_a);
        check("wave_done", wave_done, m_done);
        check("busy", busy, (m_state != S_IDLE));
        check("timeout_err", timeout_err, m_err);
        check("gnt_onehot", ($countones(gnt) <= 1), 1);
        if (gnt !== prev_gnt) check("gnt_no_direct_switch", (prev_gnt == '0 || gnt == '0), 1);
        if (wave_done === 1'b1) cur_wd++;
        if (prev_gnt == '0 && gnt != '0) begin
            for (int i = 0; i < N; i++) if (gnt[i]) gq.push_back(i);
            cur_wd = 0;
        end
        if (prev_gnt != '0 && gnt == '0) wdq.push_back(cur_wd);
        prev_gnt = gnt;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_grant(input logic [N-1:0] exp, input int budget, input string name);
        int k = 0;
        while (gnt === '0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(name, gnt, exp);
    endtask

    task automatic wait_release(input int budget, input string name);
        int k = 0;
        while (gnt !== '0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(name, gnt, '0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        bit rst_pulse;
        int hang_left;

        // 1. Reset, including a reset in the middle of DATA
        tick(3);
        check("t1_reset_gnt", gnt, 0);
        check("t1_reset_pipe_a", pipe_a, 0);
        check("t1_reset_busy", busy, 0);
        check("t1_reset_err", timeout_err, 0);
        check("t1_reset_wave_done", wave_done, 0);
        init_n = 1'b1;
        tick(2);
        req = 4'b0010;
        wait_grant(4'b0010, 20, "t1_first_grant");
        wait_release(100, "t1_first_release");
        req = 4'b0000;
        tick(8);
        req = 4'b0010;
        wait_grant(4'b0010, 20, "t1_second_grant");
        check("t1_in_data", pipe_a, 1);
        init_n = 1'b0;
        #1;
        check("t1_async_pipe_a", pipe_a, 0);
        check("t1_async_gnt", gnt, 0);
        check("t1_async_busy", busy, 0);
        req = 4'b0000;
        tick(2);
        init_n = 1'b1;
        tick(6);
        req = 4'b1001;
        wait_grant(4'b0001, 20, "t1_rr_ptr_zero");
        wait_release(100, "t1_rr_release");
        req = 4'b0000;
        tick(8);

        // 2. Single request, full burst
        req = 4'b0100;
        wait_grant(4'b0100, 20, "t2_grant");
        wait_release(100, "t2_release");
        req = 4'b0000;
        check("t2_wave_done_count", wdq[$], 2);
        tick(8);
        req = 4'b1001;
        wait_grant(4'b1000, 20, "t2_rr_ptr_3");
        wait_release(100, "t2_probe_release");
        req = 4'b0000;
        tick(8);

        // 3. Round-robin with all requesters active
        gq.delete();
        wdq.delete();
        req = 4'b1111;
        k = 0;
        while (gq.size() < 5 && k < 400) begin
            @(negedge clk);
            k++;
        end
        req = 4'b0000;
        check("t3_grant_count", (gq.size() >= 5), 1);
        if (gq.size() >= 5) begin
            check("t3_order0", gq[0], 0);
            check("t3_order1", gq[1], 1);
            check("t3_order2", gq[2], 2);
            check("t3_order3", gq[3], 3);
            check("t3_order4", gq[4], 0);
        end
        for (int i = 0; i < 4 && i < wdq.size(); i++) check("t3_burst_len", wdq[i], BURST);
        wait_release(100, "t3_release");
        tick(8);

        // 4. Request drops during the first DATA phase
        req = 4'b0010;
        wait_grant(4'b0010, 20, "t4_grant");
        req = 4'b0000;
        wait_release(100, "t4_release");
        check("t4_single_wavefront", wdq[$], 1);
        tick(8);

        // 5. Hang: ack never rises
        ack_mode = 1'b1;
        ack_force = 1'b0;
        req = 4'b0100;
        wait_grant(4'b0100, 20, "t5_grant");
        check("t5_pipe_a_high", pipe_a, 1);
        k = 0;
        while (timeout_err !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        req = 4'b0000;
        check("t5_timeout_cycles", k, TIMEOUT);
        check("t5_err_pipe_a", pipe_a, 0);
        check("t5_err_gnt", gnt, 0);
        tick(3);
        check("t5_err_sticky", timeout_err, 1);
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        check("t5_cleared", timeout_err, 0);
        check("t5_idle", busy, 0);
        ack_mode = 1'b0;
        tick(8);
        req = 4'b0101;
        wait_grant(4'b0001, 20, "t5_rr_after_err");
        wait_release(100, "t5_probe_release");
        req = 4'b0000;
        tick(8);

        // 6. Dirty start: pipeline still asserting ack
        ack_mode = 1'b1;
        ack_force = 1'b1;
        tick(4);
        req = 4'b0001;
        tick(10);
        check("t6_no_grant_dirty", gnt, 0);
        ack_force = 1'b0;
        k = 0;
        while (gnt === '0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        ack_mode = 1'b0;
        check("t6_grant_latency", k, SYNC + 1);
        check("t6_grant", gnt, 4'b0001);
        wait_release(100, "t6_release");
        req = 4'b0000;
        tick(8);

        // Randomized traffic against the model
        hang_left = 0;
        rst_pulse = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if (rst_pulse) begin
                init_n = 1'b1;
                rst_pulse = 1'b0;
            end else if ($urandom_range(0, 999) == 0) begin
                init_n = 1'b0;
                rst_pulse = 1'b1;
            end
            for (int i = 0; i < N; i++) begin
                if (!req[i]) req[i] = ($urandom_range(0, 3) == 0);
                else if (gnt[i]) req[i] = ($urandom_range(0, 2) != 0);
            end
            clr_err = ($urandom_range(0, 15) == 0);
            if (c % 200 == 0) pdelay = $urandom_range(0, 6);
            if (hang_left > 0) begin
                hang_left--;
                if (hang_left == 0) ack_mode = 1'b0;
            end else if ($urandom_range(0, 399) == 0) begin
                ack_force = pipe_ack;
                ack_mode = 1'b1;
                hang_left = $urandom_range(20, 90);
            end
        end
        req = '0;
        clr_err = 1'b0;
        ack_mode = 1'b0;
        init_n = 1'b1;
        tick(20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
